// File: rtl/f16_dot_acc_ctrl.sv
// Accumulate controller around an external FP16 FMAC (result = x*y + z).
// Streams operand pairs in, keeps the running sum and returns it on the last element.
module f16_dot_acc_ctrl #(
  parameter int unsigned FMAC_LAT = 1,
  parameter logic [15:0] INIT_ACC = 16'h0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [15:0]      in_y,
  input  logic             in_last,
  output logic [15:0]      fmac_x,
  output logic [15:0]      fmac_y,
  output logic [15:0]      fmac_z,
  input  logic [15:0]      fmac_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_CALC   = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(FMAC_LAT - 1);

  logic [1:0]       r_state;
  logic [15:0]      r_acc;
  logic [15:0]      r_fmac_x;
  logic [15:0]      r_fmac_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [3:0]       r_wait;
  logic             r_last;
  logic             r_out_valid;
  logic [15:0]      r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;

  logic             w_in_ready;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_ovf_next;
  logic             w_out_hs;

  // clr blocks acceptance in the same cycle so an aborted vector never leaks a pair
  assign w_in_ready = (r_state == ST_ACCEPT) && !clr;
  assign w_accept   = in_valid && w_in_ready;
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_ovf_next = r_ovf | (fmac_result[14:0] == 15'h7FFF);
  assign w_out_hs   = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACCEPT;
      r_acc       <= INIT_ACC;
      r_fmac_x    <= 16'h0000;
      r_fmac_y    <= 16'h0000;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_wait      <= 4'd0;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= 16'h0000;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clr) begin
      r_state     <= ST_ACCEPT;
      r_acc       <= INIT_ACC;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCEPT: begin
          if (w_accept) begin
            r_fmac_x <= in_x;
            r_fmac_y <= in_y;
            r_last   <= in_last;
            r_wait   <= WAIT_INIT;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          // result is sampled on the FMAC_LAT-th edge after the accept edge
          if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            r_acc <= fmac_result;
            r_cnt <= w_cnt_inc;
            r_ovf <= w_ovf_next;
            if (r_last) begin
              r_out_sum   <= fmac_result;
              r_out_count <= w_cnt_inc;
              r_out_ovf   <= w_ovf_next;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_ACCEPT;
            end
          end
        end
        ST_DONE: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_acc       <= INIT_ACC;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_state     <= ST_ACCEPT;
          end
        end
        default: begin
          r_state <= ST_ACCEPT;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign fmac_x    = r_fmac_x;
  assign fmac_y    = r_fmac_y;
  assign fmac_z    = r_acc;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_f16_dot_acc_ctrl.sv
// Randomized bench for f16_dot_acc_ctrl: two instances (FMAC_LAT 1 and 3) with a
// real-arithmetic FP16 FMAC model and a fold-based reference for the dot product.
`timescale 1ns/1ps
module tb_f16_dot_acc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n, clr, in_valid, in_last, out_ready, sel;
  logic [15:0] in_x, in_y;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [15:0] a_fx, a_fy, a_fz, a_res, a_out_sum, a_out_count;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [15:0] b_fx, b_fy, b_fz, b_res, b_out_sum, b_out_count;
  logic [15:0] b_pipe0 = 16'h0, b_pipe1 = 16'h0;

  logic        w_in_ready, w_out_valid, w_out_ovf;
  logic [15:0] w_fmac_x, w_fmac_y, w_fmac_z, w_out_sum, w_out_count;

  int n_chk = 0, n_pass = 0;
  int acc_cyc = 0, prev_acc_cyc = 0;
  logic [15:0] prev_x [2];
  logic [15:0] prev_y [2];
  logic [15:0] xs [8];
  logic [15:0] ys [8];
  logic [15:0] last_sum;

  f16_dot_acc_ctrl #(.FMAC_LAT(1), .INIT_ACC(16'h0000), .CNT_W(16)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid && !sel), .in_ready(a_in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .fmac_x(a_fx), .fmac_y(a_fy), .fmac_z(a_fz), .fmac_result(a_res),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum(a_out_sum), .out_count(a_out_count), .out_ovf(a_out_ovf)
  );

  f16_dot_acc_ctrl #(.FMAC_LAT(3), .INIT_ACC(16'h0000), .CNT_W(16)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid && sel), .in_ready(b_in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .fmac_x(b_fx), .fmac_y(b_fy), .fmac_z(b_fz), .fmac_result(b_res),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  assign w_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign w_out_valid = sel ? b_out_valid : a_out_valid;
  assign w_out_ovf   = sel ? b_out_ovf   : a_out_ovf;
  assign w_fmac_x    = sel ? b_fx        : a_fx;
  assign w_fmac_y    = sel ? b_fy        : a_fy;
  assign w_fmac_z    = sel ? b_fz        : a_fz;
  assign w_out_sum   = sel ? b_out_sum   : a_out_sum;
  assign w_out_count = sel ? b_out_count : a_out_count;

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real v;
    if (e == 0) v = real'(int'(h[9:0])) * pow2(-24);
    else if (e == 31) v = 131072.0;
    else v = (1.0 + real'(int'(h[9:0])) / 1024.0) * pow2(e - 15);
    return h[15] ? -v : v;
  endfunction

  // Saturating FP16 rounding: out-of-range magnitudes become 7FFF, subnormals flush to zero
  function automatic logic [15:0] r2h(input real v);
    logic s;
    real  a;
    int   e, m;
    s = (v < 0.0);
    a = s ? -v : v;
    if (a < pow2(-14)) return {s, 15'h0000};
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = $rtoi(a * 1024.0 + 0.5);
    if (m >= 2048) begin m = 1024; e++; end
    if (e > 15) return {s, 15'h7FFF};
    return {s, 5'(e + 15), 10'(m - 1024)};
  endfunction

  function automatic logic [15:0] fma16(input logic [15:0] x, y, z);
    return r2h(h2r(x) * h2r(y) + h2r(z));
  endfunction

  always_comb a_res = fma16(a_fx, a_fy, a_fz);

  always @(posedge clk) begin
    b_pipe0 <= fma16(b_fx, b_fy, b_fz);
    b_pipe1 <= b_pipe0;
  end
  assign b_res = b_pipe1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (sel=%0d cyc=%0d)", tag, got, exp, sel, cyc);
  endtask

  function automatic int lat();
    return sel ? 3 : 1;
  endfunction

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic last);
    int n = 0;
    @(negedge clk);
    in_x = x; in_y = y; in_last = last; in_valid = 1'b1;
    while (!w_in_ready && n < 60) begin
      check_eq("hold_x", w_fmac_x, prev_x[sel]);
      check_eq("hold_y", w_fmac_y, prev_y[sel]);
      @(negedge clk);
      n++;
    end
    check_eq("accept_rdy", w_in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    prev_acc_cyc = acc_cyc;
    acc_cyc = cyc;
    prev_x[sel] = x;
    prev_y[sel] = y;
    check_eq("fmac_x", w_fmac_x, x);
    check_eq("fmac_y", w_fmac_y, y);
  endtask

  task automatic wait_out(input logic [15:0] e_sum, input int e_cnt, input logic e_ovf);
    int n = 0;
    @(negedge clk);
    while (!w_out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("out_valid", w_out_valid, 1);
    check_eq("out_latency", cyc - acc_cyc, lat());
    check_eq("out_sum", w_out_sum, e_sum);
    check_eq("out_count", w_out_count, e_cnt);
    check_eq("out_ovf", w_out_ovf, e_ovf);
    last_sum = w_out_sum;
    $display("vec sel=%0d n=%0d sum=%h exp=%h count=%0d ovf=%0d", sel, e_cnt, w_out_sum, e_sum,
             w_out_count, w_out_ovf);
    if (out_ready) begin
      @(posedge clk);
      #1;
      check_eq("out_drop", w_out_valid, 0);
    end
  endtask

  // Reference: the dot product is a left fold of fma over the pairs, starting at INIT_ACC
  task automatic run_vec(input int n);
    logic [15:0] acc = 16'h0000;
    logic        ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      send(xs[i], ys[i], i == n - 1);
      check_eq("z_in", w_fmac_z, acc);
      if (i > 0) check_eq("pair_gap", acc_cyc - prev_acc_cyc, lat() + 1);
      acc = fma16(xs[i], ys[i], acc);
      ovf = ovf | (acc[14:0] == 15'h7FFF);
    end
    wait_out(acc, n, ovf);
  endtask

  function automatic logic [15:0] rnd_op();
    logic [15:0] v;
    v[15]    = 1'($urandom_range(0, 1));
    v[14:10] = 5'($urandom_range(13, 16));
    v[9:0]   = 10'($urandom);
    return v;
  endfunction

  task automatic check_reset_outputs();
    check_eq("rst_out_valid", w_out_valid, 0);
    check_eq("rst_out_sum", w_out_sum, 0);
    check_eq("rst_out_count", w_out_count, 0);
    check_eq("rst_out_ovf", w_out_ovf, 0);
    check_eq("rst_fmac_z", w_fmac_z, 16'h0000);
    check_eq("rst_fmac_x", w_fmac_x, 0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    sel = 1'b0; in_x = 16'h0; in_y = 16'h0; last_sum = 16'h0;
    prev_x[0] = 16'h0; prev_x[1] = 16'h0; prev_y[0] = 16'h0; prev_y[1] = 16'h0;
    #22;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", w_in_ready, 1);

    // basic two-element vector
    xs[0] = 16'h3C00; ys[0] = 16'h4000; xs[1] = 16'h4200; ys[1] = 16'h3800;
    run_vec(2);
    check_eq("t1_literal", last_sum, 16'h4300);

    // saturation sets ovf, which clears for the next vector
    xs[0] = 16'h7800; ys[0] = 16'h7800;
    run_vec(1);
    check_eq("ovf_literal", last_sum, 16'h7FFF);
    xs[0] = 16'h3C00; ys[0] = 16'h3C00;
    run_vec(1);
    check_eq("ovf_next_literal", last_sum, 16'h3C00);

    // backpressure in DONE with a pending pair offered
    out_ready = 1'b0;
    send(16'h3C00, 16'h4000, 1'b1);
    wait_out(16'h4000, 1, 1'b0);
    in_x = 16'h4000; in_y = 16'h3C00; in_last = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_valid", w_out_valid, 1);
      check_eq("bp_sum", w_out_sum, 16'h4000);
      check_eq("bp_count", w_out_count, 1);
      check_eq("bp_in_ready", w_in_ready, 0);
      check_eq("bp_fmac_x", w_fmac_x, 16'h3C00);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_release", w_out_valid, 0);
    check_eq("bp_keep_sum", w_out_sum, 16'h4000);
    xs[0] = 16'h4000; ys[0] = 16'h3C00;
    run_vec(1);

    // clr in CALC after the first of three elements
    send(16'h3C00, 16'h4000, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check_eq("clr_z", w_fmac_z, 16'h0000);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_x = 16'h1234; in_y = 16'h5678; in_last = 1'b1;
    #1;
    check_eq("clr_in_ready", w_in_ready, 0);
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    check_eq("clr_no_take", w_fmac_x, 16'h3C00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("clr_no_out", w_out_valid, 0);
    end
    xs[0] = 16'h4000; ys[0] = 16'h4000;
    run_vec(1);
    check_eq("clr_literal", last_sum, 16'h4400);

    // four-pair vector through the 3-cycle FMAC
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin xs[i] = rnd_op(); ys[i] = rnd_op(); end
    run_vec(4);

    // asynchronous reset in the middle of CALC
    sel = 1'b0;
    send(16'h4000, 16'h4000, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    prev_x[0] = 16'h0; prev_x[1] = 16'h0; prev_y[0] = 16'h0; prev_y[1] = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    xs[0] = 16'h3C00; ys[0] = 16'h4200;
    run_vec(1);
    check_eq("rst_next_literal", last_sum, 16'h4200);

    // randomized vectors on both latencies
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int v = 0; v < 5; v++) begin
        int n;
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin xs[i] = rnd_op(); ys[i] = rnd_op(); end
        run_vec(n);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
